// File: rtl/fetch_queue_if.sv
// Fetch front-end bus bundle: instruction-memory request/response, redirect and
// the decode-side valid/ready channel. "master" is the fetch queue, "slave" its environment.
interface fetch_queue_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [ILEN-1:0] imem_resp_data;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_inst;
  logic            out_fault;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst, out_fault,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst, out_fault,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled RV32I fetch front end: sequential requests to a variable-latency imem,
// in-order responses buffered in a DEPTH-entry FIFO, redirect flushes and drops in-flight data.
module fetch_queue #(
  parameter int unsigned    XLEN     = 32,
  parameter int unsigned    ILEN     = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic           clock,
  input logic           reset,
  fetch_queue_if.master bus
);
  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  // Back-to-back redirects can stack more than DEPTH dropped responses.
  localparam int unsigned DropW = CntW + 2;
  localparam logic [ILEN-1:0] NopInst = ILEN'(32'h0000_0013);

  typedef enum logic [0:0] {StRun, StHalt} mode_e;
  mode_e mode_q, mode_d;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d, outstanding_q, outstanding_d;
  logic [DropW-1:0] drop_q, drop_d;

  logic [XLEN-1:0]  pc_mem   [DEPTH];
  logic [ILEN-1:0]  inst_mem [DEPTH];
  logic [DEPTH-1:0] fault_mem;

  logic            aligned, has_room, req_en, fault_push;
  logic            issue, resp_push, push, pop, head_valid;
  logic [CntW:0]   occupancy;
  logic [PtrW-1:0] issue_slot;

  // Mode FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) mode_q <= StRun;
    else       mode_q <= mode_d;
  end

  // Mode FSM: next state
  always_comb begin
    mode_d = mode_q;
    if (bus.redirect)    mode_d = StRun;
    else if (fault_push) mode_d = StHalt;
  end

  // Mode FSM: outputs
  always_comb begin
    aligned    = (fetch_pc_q[1:0] == 2'b00);
    occupancy  = {1'b0, count_q} + {1'b0, outstanding_q};
    has_room   = occupancy < (CntW + 1)'(DEPTH);
    req_en     = 1'b0;
    fault_push = 1'b0;
    unique case (mode_q)
      StRun: begin
        req_en     = aligned && has_room;
        // The fault entry waits until every older response has been queued.
        fault_push = !aligned && (outstanding_q == '0) && (count_q < CntW'(DEPTH)) &&
                     !bus.redirect;
      end
      default: ;
    endcase
  end

  assign bus.imem_req_valid = !reset && !bus.redirect && req_en;
  assign bus.imem_req_addr  = fetch_pc_q;

  assign issue      = bus.imem_req_valid && bus.imem_req_ready;
  assign resp_push  = bus.imem_resp_valid && !bus.redirect && (drop_q == '0);
  assign push       = resp_push || fault_push;
  assign head_valid = (count_q != '0);
  assign pop        = head_valid && bus.out_ready;
  // Slots are reserved in issue order right behind the responses still owed.
  assign issue_slot = wr_ptr_q + PtrW'(outstanding_q);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (bus.redirect) begin
      fetch_pc_d    = bus.redirect_pc;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
      outstanding_d = '0;
      drop_d        = DropW'(outstanding_q) + drop_q - DropW'(bus.imem_resp_valid);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + XLEN'(4);
      outstanding_d = outstanding_q + CntW'(issue) - CntW'(resp_push);
      if (bus.imem_resp_valid && (drop_q != '0)) drop_d = drop_q - DropW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // Storage needs no reset: outputs are masked by head_valid.
  always_ff @(posedge clock) begin
    if (issue)      pc_mem[issue_slot] <= fetch_pc_q;
    if (fault_push) pc_mem[wr_ptr_q]   <= fetch_pc_q;
    if (push) begin
      inst_mem[wr_ptr_q]  <= resp_push ? bus.imem_resp_data : NopInst;
      fault_mem[wr_ptr_q] <= !resp_push;
    end
  end

  assign bus.out_valid = head_valid;
  assign bus.out_pc    = head_valid ? pc_mem[rd_ptr_q]    : '0;
  assign bus.out_inst  = head_valid ? inst_mem[rd_ptr_q]  : '0;
  assign bus.out_fault = head_valid ? fault_mem[rd_ptr_q] : 1'b0;
endmodule
